// File: rtl/tl_rom_port_arbiter_if.sv
// Bundle of every TileLink-UL signal around the ROM port arbiter.
//   req_a_* / req_d_* : NREQ upstream master ports; packed per-requester slices
//                       (slice i = requester i), D payload is broadcast.
//   rom_a_* / rom_d_* : the single downstream ROM slave port.
// Modports:
//   slave  : arbiter view (takes requester A and ROM D, drives ROM A and requester D).
//   master : environment view (requesters + ROM model), the mirror image.
interface tl_rom_port_arbiter_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]       req_a_valid;
  logic [NREQ-1:0]       req_a_ready;
  logic [NREQ-1:0][2:0]  req_a_opcode;
  logic [NREQ-1:0][2:0]  req_a_param;
  logic [NREQ-1:0][1:0]  req_a_size;
  logic [NREQ-1:0][10:0] req_a_source;
  logic [NREQ-1:0][16:0] req_a_address;
  logic [NREQ-1:0][7:0]  req_a_mask;
  logic [NREQ-1:0]       req_a_corrupt;
  logic [NREQ-1:0]       req_d_ready;
  logic [NREQ-1:0]       req_d_valid;
  logic [1:0]            req_d_size;
  logic [10:0]           req_d_source;
  logic [63:0]           req_d_data;

  logic                  rom_a_valid;
  logic                  rom_a_ready;
  logic [2:0]            rom_a_opcode;
  logic [2:0]            rom_a_param;
  logic [1:0]            rom_a_size;
  logic [10:0]           rom_a_source;
  logic [16:0]           rom_a_address;
  logic [7:0]            rom_a_mask;
  logic                  rom_a_corrupt;
  logic                  rom_d_valid;
  logic                  rom_d_ready;
  logic [1:0]            rom_d_size;
  logic [10:0]           rom_d_source;
  logic [63:0]           rom_d_data;

  modport slave (
    input  req_a_valid, req_a_opcode, req_a_param, req_a_size, req_a_source,
           req_a_address, req_a_mask, req_a_corrupt, req_d_ready,
           rom_a_ready, rom_d_valid, rom_d_size, rom_d_source, rom_d_data,
    output req_a_ready, req_d_valid, req_d_size, req_d_source, req_d_data,
           rom_a_valid, rom_a_opcode, rom_a_param, rom_a_size, rom_a_source,
           rom_a_address, rom_a_mask, rom_a_corrupt, rom_d_ready
  );

  modport master (
    output req_a_valid, req_a_opcode, req_a_param, req_a_size, req_a_source,
           req_a_address, req_a_mask, req_a_corrupt, req_d_ready,
           rom_a_ready, rom_d_valid, rom_d_size, rom_d_source, rom_d_data,
    input  req_a_ready, req_d_valid, req_d_size, req_d_source, req_d_data,
           rom_a_valid, rom_a_opcode, rom_a_param, rom_a_size, rom_a_source,
           rom_a_address, rom_a_mask, rom_a_corrupt, rom_d_ready
  );
endinterface

// File: rtl/tl_rom_port_arbiter.sv
// Shares the boot ROM's single TileLink-UL slave port between NREQ masters.
// A channel: round-robin grant, zero-latency combinational forward, grant
// locked across a stall so valid/payload stay stable. Every accepted beat's
// requester index goes into an in-order FIFO; the ROM answers in order, so
// the FIFO head steers each D beat back to its requester.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : tl_rom_port_arbiter_if.slave (requester and ROM channels)
//   err    : sticky protocol-error flag (D beat with nothing outstanding)
module tl_rom_port_arbiter #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 4,
  parameter int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  tl_rom_port_arbiter_if.slave        bus,
  output logic                        err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0] rr_ptr_q, rr_ptr_d, locked_idx_q, locked_idx_d;
  logic          lock_q, lock_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [IW-1:0] fifo_q [DEPTH];

  logic [IW-1:0] grant, head;
  logic          can_issue, nonempty, a_valid, a_fire, a_stall, d_fire;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign can_issue = (count_q < CW'(DEPTH));
  assign nonempty  = (count_q != '0);

  // Lowest offset from rr_ptr wins: scan offsets high to low, last hit kept.
  always_comb begin
    int idx;
    idx   = 0;
    grant = rr_ptr_q;
    if (lock_q) begin
      grant = locked_idx_q;
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (bus.req_a_valid[IW'(idx)]) grant = IW'(idx);
      end
    end
  end

  // A path
  assign a_valid = can_issue & bus.req_a_valid[grant] & ((|bus.req_a_valid) | lock_q);
  assign a_fire  = a_valid & bus.rom_a_ready;
  assign a_stall = a_valid & ~bus.rom_a_ready;

  assign bus.rom_a_valid   = a_valid;
  assign bus.rom_a_opcode  = bus.req_a_opcode[grant];
  assign bus.rom_a_param   = bus.req_a_param[grant];
  assign bus.rom_a_size    = bus.req_a_size[grant];
  assign bus.rom_a_source  = bus.req_a_source[grant];
  assign bus.rom_a_address = bus.req_a_address[grant];
  assign bus.rom_a_mask    = bus.req_a_mask[grant];
  assign bus.rom_a_corrupt = bus.req_a_corrupt[grant];

  always_comb begin
    bus.req_a_ready        = '0;
    bus.req_a_ready[grant] = can_issue & bus.rom_a_ready;
  end

  // D path: head of the tracking FIFO owns the current response.
  assign head            = fifo_q[rd_q];
  assign bus.rom_d_ready = nonempty & bus.req_d_ready[head];
  assign d_fire          = bus.rom_d_valid & bus.rom_d_ready;

  always_comb begin
    bus.req_d_valid       = '0;
    bus.req_d_valid[head] = bus.rom_d_valid & nonempty;
  end

  assign bus.req_d_size   = bus.rom_d_size;
  assign bus.req_d_source = bus.rom_d_source;
  assign bus.req_d_data   = bus.rom_d_data;

  // The 2-bit a_size field tops out at 3 (8 bytes), so a multi-beat size
  // cannot be encoded on this port; only the D-without-request error exists.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    locked_idx_d = locked_idx_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    count_d      = count_q;
    err_d        = err_q | (bus.rom_d_valid & ~nonempty);
    if (a_fire) begin
      rr_ptr_d = (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
      lock_d   = 1'b0;
      wr_d     = ptr_inc(wr_q);
    end else if (a_stall) begin
      lock_d       = 1'b1;
      locked_idx_d = grant;
    end
    if (d_fire) rd_d = ptr_inc(rd_q);
    case ({a_fire, d_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      locked_idx_q <= locked_idx_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clock) begin
    if (a_fire) fifo_q[wr_q] <= grant;
  end

  assign err = err_q;
endmodule
